d3s_frev_ts_scheduler: RTL and testbench

Queues revolution-frequency (Frev) timestamps from the host or the WR receive path. Issues them one at a time to the Frev timestamp input of the upsample/divide stage, using its valid/ready handshake. Before issuing, each timestamp is checked against current WR time and dropped if it is in the past or too close to act on. Sits between the timestamp source and d3s_upsample_divide, in the clk_wr_ref domain.

---
 rtl/d3s_frev_ts_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_d3s_frev_ts_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/d3s_frev_ts_scheduler.sv
// Frev timestamp scheduler: queues host/WR timestamps, drops late ones against WR time,
// and offers the rest one at a time to the upsample/divide stage over valid/ready.
module d3s_frev_ts_scheduler #(
   parameter int g_fifo_log2       = 2,
   parameter int g_min_lead_cycles = 16,
   parameter int g_cycles_per_sec  = 125000000
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   enable_i,
   input  logic                   flush_i,
   input  logic [31:0]            ts_tai_i,
   input  logic [31:0]            ts_nsec_i,
   input  logic                   ts_valid_i,
   output logic                   ts_ready_o,
   input  logic                   tm_time_valid_i,
   input  logic [31:0]            tm_tai_i,
   input  logic [27:0]            tm_cycles_i,
   output logic [31:0]            frev_ts_tai_o,
   output logic [31:0]            frev_ts_nsec_o,
   output logic                   frev_ts_valid_o,
   input  logic                   frev_ts_ready_i,
   output logic [g_fifo_log2:0]   fifo_count_o,
   output logic [15:0]            issued_count_o,
   output logic [15:0]            late_count_o,
   output logic [15:0]            reject_count_o,
   output logic                   busy_o
);

   localparam int                     c_depth    = 1 << g_fifo_log2;
   localparam logic [27:0]            c_lead     = 28'(g_min_lead_cycles);
   localparam logic [27:0]            c_mod      = 28'(g_cycles_per_sec);
   localparam logic [31:0]            c_nsec_max = 32'd1000000000;
   localparam logic [g_fifo_log2:0]   c_full     = (g_fifo_log2 + 1)'(c_depth);
   localparam logic [g_fifo_log2:0]   c_cnt_zero = '0;
   localparam logic [g_fifo_log2:0]   c_cnt_one  = {{g_fifo_log2{1'b0}}, 1'b1};
   localparam logic [g_fifo_log2-1:0] c_ptr_one  = (g_fifo_log2)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_OFFER = 2'd2
   } state_t;

   // Head is late if it lies in the past or within the minimum lead; the third term
   // covers a lead window that spills into the next TAI second.
   function automatic logic is_late(input logic [31:0] h_tai, input logic [31:0] h_nsec,
                                    input logic [31:0] t_tai, input logic [27:0] t_cyc);
      logic [27:0] lead_s;
      logic [28:0] hc_s;
      logic [28:0] lead_ext_s;
      logic [28:0] lead_wrap_s;
      lead_s      = t_cyc + c_lead;
      hc_s        = h_nsec[31:3];
      lead_ext_s  = {1'b0, lead_s};
      lead_wrap_s = {1'b0, lead_s - c_mod};
      is_late = (h_tai < t_tai) ||
                ((h_tai == t_tai) && (hc_s < lead_ext_s)) ||
                ((lead_s >= c_mod) && (h_tai == t_tai + 32'd1) && (hc_s < lead_wrap_s));
   endfunction

   logic [31:0]            tai_mem_r  [c_depth];
   logic [31:0]            nsec_mem_r [c_depth];
   logic [g_fifo_log2-1:0] wr_ptr_r;
   logic [g_fifo_log2-1:0] rd_ptr_r;
   logic [g_fifo_log2:0]   count_r;
   logic [g_fifo_log2:0]   count_next_s;
   logic                   ready_r;

   state_t                 state_r;
   logic                   valid_r;
   logic [31:0]            tai_out_r;
   logic [31:0]            nsec_out_r;
   logic                   busy_r;
   logic [15:0]            issued_r;
   logic [15:0]            late_r;
   logic [15:0]            reject_r;

   logic                   wr_acc_s;
   logic                   wr_ok_s;
   logic                   wr_rej_s;
   logic [31:0]            head_tai_s;
   logic [31:0]            head_nsec_s;
   logic                   late_s;
   logic                   xfer_s;
   logic                   drop_s;
   logic                   pop_s;

   // Write qualification, head lateness, pop decision and next occupancy.
   always_comb begin
      wr_acc_s    = ts_valid_i & ready_r & ~flush_i;
      wr_ok_s     = wr_acc_s & (ts_nsec_i < c_nsec_max);
      wr_rej_s    = wr_acc_s & ~(ts_nsec_i < c_nsec_max);
      head_tai_s  = tai_mem_r[rd_ptr_r];
      head_nsec_s = nsec_mem_r[rd_ptr_r];
      late_s      = is_late(head_tai_s, head_nsec_s, tm_tai_i, tm_cycles_i);
      xfer_s      = 1'b0;
      drop_s      = 1'b0;
      case (state_r)
         ST_CHECK: begin
            if (!flush_i && enable_i && tm_time_valid_i && late_s) begin
               drop_s = 1'b1;
            end else begin
               drop_s = 1'b0;
            end
         end
         ST_OFFER: begin
            if (flush_i) begin
               xfer_s = 1'b0;
            end else if (valid_r && frev_ts_ready_i && tm_time_valid_i) begin
               xfer_s = 1'b1;
            end else if (tm_time_valid_i && late_s) begin
               drop_s = 1'b1;
            end else begin
               drop_s = 1'b0;
            end
         end
         default: begin
            xfer_s = 1'b0;
            drop_s = 1'b0;
         end
      endcase
      pop_s = xfer_s | drop_s;
      if (flush_i) begin
         count_next_s = c_cnt_zero;
      end else if (wr_ok_s && !pop_s) begin
         count_next_s = count_r + c_cnt_one;
      end else if (!wr_ok_s && pop_s) begin
         count_next_s = count_r - c_cnt_one;
      end else begin
         count_next_s = count_r;
      end
   end

   // Queue storage, pointers, occupancy and registered not-full flag.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < c_depth; i++) begin
            tai_mem_r[i]  <= 32'd0;
            nsec_mem_r[i] <= 32'd0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= c_cnt_zero;
         ready_r  <= 1'b0;
      end else begin
         if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
         end else begin
            if (wr_ok_s) begin
               tai_mem_r[wr_ptr_r]  <= ts_tai_i;
               nsec_mem_r[wr_ptr_r] <= ts_nsec_i;
               wr_ptr_r             <= wr_ptr_r + c_ptr_one;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + c_ptr_one;
            end
         end
         count_r <= count_next_s;
         ready_r <= (count_next_s != c_full);
      end
   end

   // Issue FSM with registered offer outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r    <= ST_IDLE;
         valid_r    <= 1'b0;
         tai_out_r  <= 32'd0;
         nsec_out_r <= 32'd0;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!flush_i && enable_i && (count_r != c_cnt_zero)) begin
                  state_r <= ST_CHECK;
                  busy_r  <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (flush_i || !enable_i || drop_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (tm_time_valid_i) begin
                  tai_out_r  <= head_tai_s;
                  nsec_out_r <= head_nsec_s;
                  valid_r    <= 1'b1;
                  state_r    <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (flush_i || pop_s || !enable_i) begin
                  valid_r <= 1'b0;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               valid_r <= 1'b0;
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         issued_r <= 16'd0;
         late_r   <= 16'd0;
         reject_r <= 16'd0;
      end else begin
         if (xfer_s && (issued_r != 16'hFFFF)) begin
            issued_r <= issued_r + 16'd1;
         end
         if (drop_s && (late_r != 16'hFFFF)) begin
            late_r <= late_r + 16'd1;
         end
         if (wr_rej_s && (reject_r != 16'hFFFF)) begin
            reject_r <= reject_r + 16'd1;
         end
      end
   end

   assign ts_ready_o      = ready_r;
   assign frev_ts_tai_o   = tai_out_r;
   assign frev_ts_nsec_o  = nsec_out_r;
   assign frev_ts_valid_o = valid_r;
   assign fifo_count_o    = count_r;
   assign issued_count_o  = issued_r;
   assign late_count_o    = late_r;
   assign reject_count_o  = reject_r;
   assign busy_o          = busy_r;

endmodule

// File: tb/tb_d3s_frev_ts_scheduler.sv
// Directed bench for d3s_frev_ts_scheduler: issue, late drop, second wrap, backpressure,
// late-while-offered, reject, flush, enable hold-off and asynchronous reset.
module tb_d3s_frev_ts_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        flush;
   logic [31:0] ts_tai;
   logic [31:0] ts_nsec;
   logic        ts_valid;
   logic        ts_ready;
   logic        tm_valid;
   logic [31:0] tm_tai;
   logic [27:0] tm_cycles;
   logic [31:0] frev_tai;
   logic [31:0] frev_nsec;
   logic        frev_valid;
   logic        frev_ready;
   logic [2:0]  fifo_count;
   logic [15:0] issued_count;
   logic [15:0] late_count;
   logic [15:0] reject_count;
   logic        busy;

   int errors = 0;
   int checks = 0;

   d3s_frev_ts_scheduler #(
      .g_fifo_log2      (2),
      .g_min_lead_cycles(16),
      .g_cycles_per_sec (125000000)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .enable_i       (enable),
      .flush_i        (flush),
      .ts_tai_i       (ts_tai),
      .ts_nsec_i      (ts_nsec),
      .ts_valid_i     (ts_valid),
      .ts_ready_o     (ts_ready),
      .tm_time_valid_i(tm_valid),
      .tm_tai_i       (tm_tai),
      .tm_cycles_i    (tm_cycles),
      .frev_ts_tai_o  (frev_tai),
      .frev_ts_nsec_o (frev_nsec),
      .frev_ts_valid_o(frev_valid),
      .frev_ts_ready_i(frev_ready),
      .fifo_count_o   (fifo_count),
      .issued_count_o (issued_count),
      .late_count_o   (late_count),
      .reject_count_o (reject_count),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] tai, input logic [31:0] nsec);
      ts_tai   = tai;
      ts_nsec  = nsec;
      ts_valid = 1'b1;
      step();
      ts_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20 && !frev_valid; i++) step();
      chk(tag, {31'd0, frev_valid}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; flush = 1'b0;
      ts_tai = 32'd0; ts_nsec = 32'd0; ts_valid = 1'b0;
      tm_valid = 1'b1; tm_tai = 32'd100; tm_cycles = 28'd1000;
      frev_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ts_ready}, 32'd0);
      chk("rst_valid", {31'd0, frev_valid}, 32'd0);
      chk("rst_count", {29'd0, fifo_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("ready_after_rst", {31'd0, ts_ready}, 32'd1);

      // Plain issue: valid two edges after the write
      wr(32'd100, 32'd80000);
      chk("issue_n0_valid", {31'd0, frev_valid}, 32'd0);
      chk("issue_n0_count", {29'd0, fifo_count}, 32'd1);
      step();
      chk("issue_n1_valid", {31'd0, frev_valid}, 32'd0);
      step();
      chk("issue_n2_valid", {31'd0, frev_valid}, 32'd1);
      chk("issue_tai", frev_tai, 32'd100);
      chk("issue_nsec", frev_nsec, 32'd80000);
      step();
      chk("issue_done_valid", {31'd0, frev_valid}, 32'd0);
      chk("issue_cnt", {16'd0, issued_count}, 32'd1);
      chk("issue_empty", {29'd0, fifo_count}, 32'd0);

      // Late drop with zero lead
      tm_cycles = 28'd10000;
      wr(32'd100, 32'd80000);
      step();
      step();
      chk("late_valid", {31'd0, frev_valid}, 32'd0);
      chk("late_cnt", {16'd0, late_count}, 32'd1);
      chk("late_empty", {29'd0, fifo_count}, 32'd0);

      // Lead window wrapping into the next second
      tm_cycles = 28'd124999990;
      wr(32'd101, 32'd40);
      step();
      step();
      chk("wrap_late_cnt", {16'd0, late_count}, 32'd2);
      chk("wrap_late_valid", {31'd0, frev_valid}, 32'd0);
      wr(32'd101, 32'd200);
      step();
      step();
      chk("wrap_issue_valid", {31'd0, frev_valid}, 32'd1);
      chk("wrap_issue_nsec", frev_nsec, 32'd200);
      step();
      chk("wrap_issue_cnt", {16'd0, issued_count}, 32'd2);

      // Backpressure: six writes, only four fit
      tm_cycles = 28'd1000;
      frev_ready = 1'b0;
      for (int k = 1; k <= 6; k++) wr(32'd100, 32'd100000 + 32'(k) * 32'd8);
      chk("full_ready", {31'd0, ts_ready}, 32'd0);
      chk("full_count", {29'd0, fifo_count}, 32'd4);
      chk("full_valid", {31'd0, frev_valid}, 32'd1);
      chk("full_nsec1", frev_nsec, 32'd100008);
      frev_ready = 1'b1;
      step();
      chk("pop1_issued", {16'd0, issued_count}, 32'd3);
      chk("pop1_count", {29'd0, fifo_count}, 32'd3);
      chk("pop1_ready", {31'd0, ts_ready}, 32'd1);
      for (int k = 2; k <= 4; k++) begin
         wait_valid("order_valid");
         chk("order_nsec", frev_nsec, 32'd100000 + 32'(k) * 32'd8);
         step();
      end
      chk("drain_issued", {16'd0, issued_count}, 32'd6);
      chk("drain_count", {29'd0, fifo_count}, 32'd0);

      // Head turns late while being offered
      frev_ready = 1'b0;
      wr(32'd100, 32'd16000);
      wr(32'd100, 32'd80000);
      wait_valid("lwo_valid");
      chk("lwo_nsec_a", frev_nsec, 32'd16000);
      tm_cycles = 28'd1984;
      step();
      chk("lwo_edge_hold", {31'd0, frev_valid}, 32'd1);
      tm_cycles = 28'd1985;
      step();
      chk("lwo_withdraw", {31'd0, frev_valid}, 32'd0);
      chk("lwo_late_cnt", {16'd0, late_count}, 32'd3);
      chk("lwo_count", {29'd0, fifo_count}, 32'd1);
      wait_valid("lwo_next_valid");
      chk("lwo_nsec_b", frev_nsec, 32'd80000);

      // Reject out-of-range nsec, then flush during an offer
      wr(32'd100, 32'd1000000000);
      chk("rej_cnt", {16'd0, reject_count}, 32'd1);
      chk("rej_count", {29'd0, fifo_count}, 32'd1);
      wr(32'd100, 32'd90000);
      wr(32'd100, 32'd95000);
      chk("pre_flush_count", {29'd0, fifo_count}, 32'd3);
      chk("pre_flush_valid", {31'd0, frev_valid}, 32'd1);
      flush = 1'b1;
      ts_tai = 32'd100; ts_nsec = 32'd99000; ts_valid = 1'b1;
      step();
      flush = 1'b0; ts_valid = 1'b0;
      chk("flush_valid", {31'd0, frev_valid}, 32'd0);
      chk("flush_count", {29'd0, fifo_count}, 32'd0);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_issued", {16'd0, issued_count}, 32'd6);
      chk("flush_late", {16'd0, late_count}, 32'd3);
      chk("flush_reject", {16'd0, reject_count}, 32'd1);
      step();
      chk("post_flush_count", {29'd0, fifo_count}, 32'd0);

      // Enable low holds the entry in the queue
      enable = 1'b0;
      wr(32'd100, 32'd40000);
      step();
      step();
      chk("en_valid", {31'd0, frev_valid}, 32'd0);
      chk("en_count", {29'd0, fifo_count}, 32'd1);
      chk("en_busy", {31'd0, busy}, 32'd0);
      enable = 1'b1;
      wait_valid("en_resume_valid");
      chk("en_resume_nsec", frev_nsec, 32'd40000);

      // Asynchronous reset mid-offer
      rst_n = 1'b0;
      #1;
      chk("async_valid", {31'd0, frev_valid}, 32'd0);
      chk("async_issued", {16'd0, issued_count}, 32'd0);
      chk("async_count", {29'd0, fifo_count}, 32'd0);
      chk("async_ready", {31'd0, ts_ready}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
